// File: rtl/lcd_menu_programmer.sv
// lcd_menu_programmer: button-driven mode menu that redraws the LCD through an Avalon-MM slave
module lcd_menu_programmer #(
    parameter int N_MODES     = 5,
    parameter int MAX_CHARS   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           left,
    input  logic                           right,
    input  logic                           select,
    output logic [$clog2(N_MODES)-1:0]     filter_mode,
    output logic [$clog2(N_MODES)-1:0]     highlight,
    output logic                           busy,
    output logic                           err,
    output logic [$clog2(N_MODES)-1:0]     txt_mode,
    output logic [$clog2(MAX_CHARS)-1:0]   txt_idx,
    input  logic [8:0]                     txt_word,
    input  logic [$clog2(MAX_CHARS+1)-1:0] txt_len,
    output logic                           address,
    output logic                           chipselect,
    output logic                           byteenable,
    output logic                           read,
    output logic                           write,
    input  logic                           waitrequest,
    input  logic [7:0]                     readdata,
    input  logic [1:0]                     response,
    output logic [7:0]                     writedata
);
    localparam int MW = $clog2(N_MODES);
    localparam int CW = $clog2(MAX_CHARS);
    localparam int LW = $clog2(MAX_CHARS + 1);
    localparam int KW = $clog2(MAX_CHARS + 3);
    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [MW-1:0] LAST_MODE = MW'(N_MODES - 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_CHARS);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
    state_t state, state_next;

    logic          l_q, r_q, s_q, l_e, r_e, s_e;
    logic          pending, mark, stall, done, last, finish, tmo, go_load, unused_in;
    logic [MW-1:0] mode, hl_inc, hl_dec;
    logic [LW-1:0] len, len_clamped;
    logic [KW-1:0] k;
    logic [TW-1:0] wcnt;
    logic [8:0]    nxt_word;

    assign l_e         = left & ~l_q;
    assign r_e         = right & ~r_q;
    assign s_e         = select & ~s_q;
    assign hl_inc      = highlight == LAST_MODE ? '0 : highlight + 1'b1;
    assign hl_dec      = highlight == '0 ? LAST_MODE : highlight - 1'b1;
    assign len_clamped = txt_len > MAX_LEN ? MAX_LEN : txt_len;
    assign stall       = state == WRITE && waitrequest;
    assign done        = state == WRITE && !waitrequest;
    assign last        = k == KW'(len) + KW'(mark);
    assign finish      = done && (last || pending);
    assign tmo         = TIMEOUT_CYC > 0 && stall && int'(wcnt) == TIMEOUT_CYC - 1;
    assign go_load     = state_next == LOAD;
    assign nxt_word    = k + 1'b1 <= KW'(len) ? txt_word : 9'h12A;
    assign txt_mode    = state == LOAD ? highlight : mode;
    assign txt_idx     = CW'(k);
    assign busy        = state != IDLE;
    assign byteenable  = 1'b1;
    assign read        = 1'b0;
    assign unused_in   = ^{readdata, response};

    // sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next state: a pending refresh restarts the screen once the current word lands
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pending ? LOAD : IDLE;
            LOAD:    state_next = WRITE;
            default: state_next = tmo ? IDLE : finish ? (pending ? LOAD : IDLE) : WRITE;
        endcase
    end

    // buttons, menu registers, sequence counters and registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {l_q, r_q, s_q} <= '1;
            highlight       <= '0;
            filter_mode     <= '0;
            pending         <= 1'b1;
            err             <= 1'b0;
            chipselect      <= 1'b0;
            write           <= 1'b0;
            address         <= 1'b0;
            writedata       <= '0;
            mode            <= '0;
            len             <= '0;
            mark            <= 1'b0;
            k               <= '0;
            wcnt            <= '0;
        end else begin
            l_q       <= left;
            r_q       <= right;
            s_q       <= select;
            highlight <= r_e && !l_e ? hl_inc : l_e && !r_e ? hl_dec : highlight;
            if (s_e) filter_mode <= highlight;
            pending   <= go_load ? 1'b0 : pending | (l_e ^ r_e) | s_e;
            wcnt      <= stall ? wcnt + 1'b1 : '0;
            if (tmo) begin
                err        <= 1'b1;
                write      <= 1'b0;
                chipselect <= 1'b0;
            end else if (state == LOAD) begin
                mode       <= highlight;
                len        <= len_clamped;
                mark       <= highlight == filter_mode;
                k          <= '0;
                write      <= 1'b1;
                chipselect <= 1'b1;
                address    <= 1'b0;
                writedata  <= 8'h01;
            end else if (finish) begin
                write      <= 1'b0;
                chipselect <= 1'b0;
            end else if (done) begin
                k         <= k + 1'b1;
                address   <= nxt_word[8];
                writedata <= nxt_word[7:0];
            end
        end
    end
endmodule

// File: tb/tb_lcd_menu_programmer.sv
// tb_lcd_menu_programmer: randomized menu driving with a screen-level scoreboard
module tb_lcd_menu_programmer;
    localparam int N  = 5;
    localparam int MC = 16;
    localparam int TO = 8;

    logic       clk = 0, reset = 1, left = 0, right = 0, select = 0, waitrequest = 0;
    logic [2:0] filter_mode, highlight, txt_mode;
    logic [3:0] txt_idx;
    logic [8:0] txt_word;
    logic [4:0] txt_len;
    logic       busy, err, address, chipselect, byteenable, read, write;
    logic [7:0] writedata;

    logic [7:0] chars [N][MC];
    logic [4:0] lens [N];

    typedef struct {
        logic [8:0] w [MC+2];
        int         n;
        int         hl;
        int         fm;
    } scr_t;
    scr_t exp_q[$];

    int compared = 0, mismatched = 0;
    int m_hl = 0, m_fm = 0;
    bit rnd_wr = 1, stuck = 0, ignore = 0;
    logic [8:0] cur [MC+3];
    int cur_n = 0, starts = 0, stuck_w = 0;
    bit prev_busy = 0, prev_stall = 0;
    logic [8:0] prev_word;

    lcd_menu_programmer #(.N_MODES(N), .MAX_CHARS(MC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .left(left), .right(right), .select(select),
        .filter_mode(filter_mode), .highlight(highlight), .busy(busy), .err(err),
        .txt_mode(txt_mode), .txt_idx(txt_idx), .txt_word(txt_word), .txt_len(txt_len),
        .address(address), .chipselect(chipselect), .byteenable(byteenable), .read(read),
        .write(write), .waitrequest(waitrequest), .readdata(8'h00), .response(2'b00),
        .writedata(writedata)
    );

    assign txt_word = int'(txt_mode) < N ? {1'b1, chars[int'(txt_mode)][int'(txt_idx)]} : 9'h100;
    assign txt_len  = int'(txt_mode) < N ? lens[int'(txt_mode)] : 5'd0;

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic scr_t model();
        scr_t s;
        int l;
        s.n = 0;
        s.w[s.n++] = 9'h001;
        l = int'(lens[m_hl]) > MC ? MC : int'(lens[m_hl]);
        for (int i = 0; i < l; i++) s.w[s.n++] = {1'b1, chars[m_hl][i]};
        if (m_hl == m_fm) s.w[s.n++] = 9'h12A;
        s.hl = m_hl;
        s.fm = m_fm;
        return s;
    endfunction

    // Monitor: assemble completed writes into screens; compare when a refresh ends
    always @(negedge clk) begin
        if (reset) begin
            cur_n = 0;
            prev_busy = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall && !stuck)
                chk(write && chipselect && {address, writedata} == prev_word, "stall_hold",
                    int'({address, writedata}), int'(prev_word));
            if (stuck && write) stuck_w++;
            if (!prev_busy && busy) cur_n = 0;
            if (chipselect && write && !waitrequest) begin
                if ({address, writedata} == 9'h001) begin
                    cur_n = 0;
                    starts++;
                end
                if (cur_n < MC + 3) cur[cur_n++] = {address, writedata};
                else chk(0, "screen_overflow", cur_n, MC + 2);
            end
            if (prev_busy && !busy) begin
                if (ignore) ignore = 0;
                else if (exp_q.size() == 0) chk(0, "unexpected_refresh", 1, 0);
                else begin
                    scr_t e;
                    int bad;
                    e = exp_q.pop_front();
                    bad = -1;
                    for (int i = 0; i < e.n && i < cur_n; i++)
                        if (bad < 0 && cur[i] !== e.w[i]) bad = i;
                    chk(cur_n == e.n, "screen_len", cur_n, e.n);
                    if (bad >= 0) chk(0, "screen_word", int'(cur[bad]), int'(e.w[bad]));
                    else chk(1, "screen_word", 0, 0);
                    chk(int'(highlight) == e.hl && int'(filter_mode) == e.fm, "menu_regs",
                        int'(highlight) * 16 + int'(filter_mode), e.hl * 16 + e.fm);
                end
            end
            prev_busy = busy;
            prev_stall = chipselect && write && waitrequest;
            prev_word = {address, writedata};
        end
    end

    // Waitrequest driver: random short stalls, or stuck high
    initial begin
        int run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stuck) waitrequest = 1;
            else if (rnd_wr && run < 3 && $urandom_range(0, 3) == 0) begin
                waitrequest = 1;
                run++;
            end else begin
                waitrequest = 0;
                run = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input bit l, input bit r, input bit s);
        left = l;
        right = r;
        select = s;
        tick(1);
        left = 0;
        right = 0;
        select = 0;
        tick(1);
        if (s) m_fm = m_hl;
        if (r && !l) m_hl = (m_hl + 1) % N;
        if (l && !r) m_hl = (m_hl + N - 1) % N;
    endtask

    task automatic wait_idle();
        int c = 0;
        tick(3);
        while (busy && c < 600) begin
            tick(1);
            c++;
        end
        if (c >= 600) chk(0, "idle_timeout", c, 600);
        tick(2);
    endtask

    task automatic press(input bit l, input bit r, input bit s);
        apply(l, r, s);
        if (s || (l ^ r)) exp_q.push_back(model());
        wait_idle();
    endtask

    initial begin
        int c, st0;
        for (int m = 0; m < N; m++) begin
            lens[m] = 5'($urandom_range(0, 20));
            for (int i = 0; i < MC; i++) chars[m][i] = 8'($urandom_range(32, 126));
        end
        lens[0] = 4;
        chars[0][0] = "N";
        chars[0][1] = "o";
        chars[0][2] = "F";
        chars[0][3] = "l";
        right = 1;
        tick(2);
        chk(filter_mode == 0 && highlight == 0, "reset_menu", int'(highlight), 0);
        chk(err == 0 && busy == 0, "reset_flags", int'({err, busy}), 0);
        chk(chipselect == 0 && write == 0, "reset_bus_ctl", int'({chipselect, write}), 0);
        chk({address, writedata} == 9'h000, "reset_bus_data", int'({address, writedata}), 0);
        chk(byteenable == 1 && read == 0, "tied_outputs", int'({byteenable, read}), 2);
        exp_q.push_back(model());
        st0 = starts;
        reset = 0;
        tick(3);
        right = 0;
        wait_idle();
        chk(starts - st0 == 1, "initial_refresh_count", starts - st0, 1);
        chk(cur_n == 6 && cur[5] == 9'h12A, "initial_nofl_marker", int'(cur[5]), 'h12A);
        chk(highlight == 0, "held_button_no_fire", int'(highlight), 0);

        press(1, 0, 0);
        chk(highlight == 4 && filter_mode == 0, "left_wrap", int'(highlight), 4);
        press(0, 1, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        press(0, 0, 1);
        chk(highlight == 2 && filter_mode == 2, "right_select", int'(filter_mode), 2);

        for (int it = 0; it < 40; it++) begin
            int a;
            if ($urandom_range(0, 3) == 0) begin
                int m = $urandom_range(0, N - 1);
                lens[m] = 5'($urandom_range(0, 20));
                for (int i = 0; i < MC; i++) chars[m][i] = 8'($urandom_range(32, 126));
            end
            a = $urandom_range(0, 4);
            case (a)
                0: press(1, 0, 0);
                1: press(0, 1, 0);
                2: press(0, 0, 1);
                3: begin
                    press(1, 1, 0);
                    chk(int'(highlight) == m_hl && !busy, "both_no_change", int'(highlight), m_hl);
                end
                default: press(1, 0, 1);
            endcase
        end

        rnd_wr = 0;
        for (int m = 0; m < N; m++) lens[m] = 5'($urandom_range(3, 20));
        tick(2);
        st0 = starts;
        apply(1, 0, 0);
        c = 0;
        while (!busy && c < 20) begin
            tick(1);
            c++;
        end
        while (cur_n < 2 && c < 100) begin
            tick(1);
            c++;
        end
        chk(c < 100, "midseq_reach_k2", c, 100);
        apply(0, 1, 0);
        exp_q.push_back(model());
        wait_idle();
        chk(starts - st0 == 2, "midseq_restart", starts - st0, 2);

        stuck = 1;
        tick(2);
        stuck_w = 0;
        ignore = 1;
        apply(1, 0, 0);
        c = 0;
        while (!err && c < 100) begin
            tick(1);
            c++;
        end
        chk(err == 1, "timeout_err", int'(err), 1);
        chk(write == 0 && chipselect == 0, "timeout_drop", int'({write, chipselect}), 0);
        chk(stuck_w == TO, "timeout_cycles", stuck_w, TO);
        tick(3);
        chk(busy == 0, "timeout_idle", int'(busy), 0);
        stuck = 0;
        tick(2);
        press(1, 1, 0);
        chk(int'(highlight) == m_hl && busy == 0, "timeout_both_no_change", int'(highlight), m_hl);
        chk(err == 1, "err_sticky", int'(err), 1);
        press(0, 0, 1);

        rnd_wr = 1;
        apply(0, 1, 0);
        c = 0;
        while (!write && c < 50) begin
            tick(1);
            c++;
        end
        reset = 1;
        #1;
        chk(write == 0 && chipselect == 0, "async_reset_drop", int'({write, chipselect}), 0);
        tick(2);
        m_hl = 0;
        m_fm = 0;
        chk(err == 0 && highlight == 0, "reset_clears_err", int'(err), 0);
        exp_q.push_back(model());
        reset = 0;
        wait_idle();
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
